// File: rtl/instr_loader.sv
// instr_loader: writer side of the CPU instruction port.
// Assembles 9-bit words from a serial LSB-first bit stream into a small
// program buffer, then replays the buffer to the CPU as one-cycle
// INSTRUCTION/write_en beats separated by GAP idle cycles.
// Optional build macro: INSTR_LOADER_LOOP_EN (continuous replay with
// start acting as a stop request while streaming).
module instr_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int GAP    = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ser_bit,
  input  logic              ser_valid,
  input  logic              load_done,
  input  logic              clear,
  input  logic              start,
  output logic [8:0]        INSTRUCTION,
  output logic              write_en,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_GAPW = 2'd3;

  localparam logic              GAP_EN   = (GAP > 0);
  localparam logic [2:0]        GAP_M1   = (GAP > 0) ? 3'(GAP - 1) : 3'd0;
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] RD_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] RD_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [1:0]        state_nx_s;
  logic [7:0]        shift_r;
  logic [3:0]        bitcnt_r;
  logic [8:0]        mem_r [DEPTH];
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W-1:0] rd_r;
  logic [2:0]        gapcnt_r;
  logic [8:0]        instr_r;
  logic              we_r;
  logic              busy_r;
  logic              overflow_r;

  logic              last_s;
  logic              full_s;
  logic              go_s;
  logic              word_done_s;
  logic              mem_we_s;

  assign last_s      = ({1'b0, rd_r} == (count_r - CNT_ONE));
  assign full_s      = (count_r == CNT_FULL);
  assign go_s        = start && (count_r != CNT_ZERO);
  // Ninth bit arriving in LOAD completes a word (unless the session ends now).
  assign word_done_s = (state_r == ST_LOAD) && !load_done && ser_valid && (bitcnt_r == 4'd8);
  assign mem_we_s    = word_done_s && !full_s && !RESET;

  // Next-state selection for the load/stream sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          state_nx_s = ST_RUN;
        end else if (clear) begin
          state_nx_s = ST_IDLE;
        end else if (ser_valid) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_RUN: begin
`ifdef INSTR_LOADER_LOOP_EN
        if (start) begin
          state_nx_s = ST_IDLE;
        end else if (GAP_EN) begin
          state_nx_s = ST_GAPW;
        end else begin
          state_nx_s = ST_RUN;
        end
`else
        if (last_s) begin
          state_nx_s = ST_IDLE;
        end else if (GAP_EN) begin
          state_nx_s = ST_GAPW;
        end else begin
          state_nx_s = ST_RUN;
        end
`endif
      end
      ST_GAPW: begin
`ifdef INSTR_LOADER_LOOP_EN
        if (start) begin
          state_nx_s = ST_IDLE;
        end else if (gapcnt_r == 3'd0) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_GAPW;
        end
`else
        if (gapcnt_r == 3'd0) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_GAPW;
        end
`endif
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Program buffer write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_r[count_r[ADDR_W-1:0]] <= {ser_bit, shift_r};
    end
  end

  // Sequencer state, serial assembly, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'd0;
      bitcnt_r   <= 4'd0;
      count_r    <= CNT_ZERO;
      rd_r       <= RD_ZERO;
      gapcnt_r   <= 3'd0;
      instr_r    <= 9'd0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      we_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            rd_r <= RD_ZERO;
          end else if (clear) begin
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
          end else if (ser_valid) begin
            shift_r[0] <= ser_bit;
            bitcnt_r   <= 4'd1;
          end
        end
        ST_LOAD: begin
          if (load_done) begin
            bitcnt_r <= 4'd0;
          end else if (ser_valid) begin
            if (bitcnt_r == 4'd8) begin
              bitcnt_r <= 4'd0;
              if (full_s) begin
                overflow_r <= 1'b1;
              end else begin
                count_r <= count_r + CNT_ONE;
              end
            end else begin
              shift_r[bitcnt_r[2:0]] <= ser_bit;
              bitcnt_r               <= bitcnt_r + 4'd1;
            end
          end
        end
        ST_RUN: begin
`ifdef INSTR_LOADER_LOOP_EN
          // A stop request ends streaming without issuing another beat.
          if (!start) begin
            instr_r  <= mem_r[rd_r];
            we_r     <= 1'b1;
            gapcnt_r <= GAP_M1;
            rd_r     <= last_s ? RD_ZERO : (rd_r + RD_ONE);
          end
`else
          instr_r  <= mem_r[rd_r];
          we_r     <= 1'b1;
          gapcnt_r <= GAP_M1;
          if (!last_s) begin
            rd_r <= rd_r + RD_ONE;
          end
`endif
        end
        ST_GAPW: begin
          if (gapcnt_r != 3'd0) begin
            gapcnt_r <= gapcnt_r - 3'd1;
          end
        end
        default: begin
          we_r <= 1'b0;
        end
      endcase
    end
  end

  assign INSTRUCTION = instr_r;
  assign write_en    = we_r;
  assign count       = count_r;
  assign busy        = busy_r;
  assign overflow    = overflow_r;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the CPU instruction port: assembles 9-bit instruction words from a 1-bit serial input and stores them in a small program buffer.
- On command, streams the stored words to the CPU as one-cycle INSTRUCTION/write_en beats.
- Sits between the chip input pins and the CPU core.
- Lets a host load a program once and replay it with deterministic pacing.

Parameters:
DEPTH, 8, number of 9-bit words in the program buffer (power of two, 2..16)
ADDR_W, 3, log2(DEPTH)
GAP, 0, idle cycles inserted between consecutive write_en beats (0..7)

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous reset, active-high
ser_bit  input  1  serial instruction data, LSB first
ser_valid  input  1  ser_bit is sampled on this edge
load_done  input  1  end load session; discard partial word
clear  input  1  empty the program buffer (IDLE only)
start  input  1  begin streaming (IDLE); stop request in RUN when LOOP_EN is defined
INSTRUCTION  output  9  registered instruction word to CPU
write_en  output  1  one-cycle strobe, INSTRUCTION valid
count  output  ADDR_W+1  number of stored words, 0..DEPTH
busy  output  1  high in LOAD and RUN
overflow  output  1  sticky: a completed word was dropped because the buffer was full

Behaviour:
- Clock and reset: one clock CLK; RESET is synchronous and active-high, sampled only on the CLK rising edge.
- Reset values: state=IDLE, INSTRUCTION=0, write_en=0, count=0, busy=0, overflow=0, bit counter=0, read pointer=0. Buffer contents are not cleared.
- Reset mid-LOAD or mid-RUN aborts on that edge. write_en is low in the following cycle.
- States: IDLE, LOAD, RUN, GAPW.
- IDLE:
  - start=1 with count>0 → RUN, rd=0. start has priority over ser_valid and clear on the same edge.
  - start with count=0 is ignored.
  - clear=1 → count=0, overflow=0.
  - ser_valid=1 → LOAD; that bit is captured as bit 0.
- LOAD:
  - Each ser_valid edge writes ser_bit into shift[bitcnt] and increments bitcnt.
  - On the edge capturing bit 8, the complete word is written to buf[count] and count increments; bitcnt returns to 0.
  - If count==DEPTH, the word is dropped and overflow is set.
  - load_done=1 → IDLE, bitcnt=0, partial bits discarded. If ser_valid is also asserted, that bit is discarded.
  - start and clear are ignored in LOAD.
- RUN:
  - Each RUN edge registers INSTRUCTION<=buf[rd] and write_en<=1, so the first beat is valid the cycle after RUN is entered. Latency is start sampled → write_en high: 2 edges.
  - After issuing, if rd==count-1, the end-of-program rule applies. Otherwise rd increments, and the block goes to GAPW if GAP>0, else stays in RUN.
  - End of program, without LOOP_EN: next state IDLE; write_en drops on the following edge.
  - ser_valid and clear are ignored in RUN.
- GAPW: write_en=0 for exactly GAP cycles, then RUN.
- Outputs:
  - write_en is high for exactly one cycle per word.
  - INSTRUCTION holds its last value when write_en is low.
  - count and buffer contents are preserved after RUN, so start replays the program.
- Widths: count saturates at DEPTH; rd wraps modulo count (LOOP_EN only).

Optional Feature:
- Macro: INSTR_LOADER_LOOP_EN.
- Defined:
  - At end of program, rd wraps to 0 and streaming continues indefinitely.
  - start=1 seen in RUN/GAPW sets a stop request. The current beat completes, then → IDLE; no further beats.
- Undefined:
  - Single pass only.
  - start in RUN/GAPW is ignored.

Test Plan:
- Reset, shift 9'h1A5 LSB first (bits 1,0,1,0,0,1,0,1,1), pulse load_done, then start, GAP=0 → count=1; exactly one write_en beat with INSTRUCTION=9'h1A5 two edges after start; busy low after.
- Load 3 words 9'h001, 9'h0F2, 9'h155, GAP=2, start → beats 9'h001, 9'h0F2, 9'h155 on cycles t, t+3, t+6; write_en low otherwise.
- Load DEPTH+1 words → count=8, overflow=1, 9th word absent on replay. clear in IDLE → count=0, overflow=0.
- Shift 5 bits, load_done, then full word 9'h0AA → count=1, stored word 9'h0AA (partial discarded).
- Assert RESET during RUN of a 4-word program after the 2nd beat → write_en=0 next cycle, state IDLE, count=0.
- With INSTR_LOADER_LOOP_EN, 2 words 9'h011, 9'h022, GAP=0 → beats 011, 022, 011, 022, …; start pulse during a beat → that beat completes, then no further write_en.
